// File: rtl/dscnn_pkg.sv
// Shared DS-CNN datapath constants, lane typedefs and width helpers.
package dscnn_pkg;

    localparam int DEF_N_MACS = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_PROD_W = 2 * DEF_DATA_W;

    typedef logic signed [DEF_DATA_W-1:0] lane_t;
    typedef lane_t [DEF_N_MACS-1:0]       lane_vec_t;
    typedef logic signed [DEF_PROD_W-1:0] prod_t;

    // Exact width of a sum of n_macs products; the reduction can never overflow it.
    function automatic int sum_w(input int n_macs, input int data_w);
        return 2 * data_w + $clog2(n_macs);
    endfunction

endpackage

// File: rtl/mac_array_if.sv
// Controller <-> MAC engine interface: lane operands, clear/bias control and results.
interface mac_array_if #(
    parameter int N_MACS = dscnn_pkg::DEF_N_MACS,
    parameter int DATA_W = dscnn_pkg::DEF_DATA_W,
    parameter int ACC_W  = dscnn_pkg::DEF_ACC_W
);
    // No ready path: the engine accepts one beat per cycle, so mac_en alone
    // qualifies a beat; mac_valid qualifies mac_acc for every beat since the last clear.
    logic                           mac_en;
    logic                           mac_clear;
    logic [N_MACS-1:0][DATA_W-1:0]  mac_ifmap;
    logic [N_MACS-1:0][DATA_W-1:0]  mac_weight;
    logic [ACC_W-1:0]               mac_bias;
    logic [ACC_W-1:0]               mac_acc;
    logic                           mac_valid;
    logic                           mac_ovf;

    modport master (
        output mac_en, mac_clear, mac_ifmap, mac_weight, mac_bias,
        input  mac_acc, mac_valid, mac_ovf
    );

    modport slave (
        input  mac_en, mac_clear, mac_ifmap, mac_weight, mac_bias,
        output mac_acc, mac_valid, mac_ovf
    );
endinterface

// File: rtl/mac_adder_tree.sv
// Combinational pairwise reduction of N_MACS signed products to one exact-width sum.
module mac_adder_tree #(
    parameter int N_MACS = 16,
    parameter int PROD_W = 16,
    parameter int SUM_W  = 20
) (
    input  logic [N_MACS-1:0][PROD_W-1:0] prod_i,
    output logic signed [SUM_W-1:0]       sum_o
);

    // Heap layout: leaves at N_MACS-1 .. 2*N_MACS-2, root at index 0.
    logic signed [SUM_W-1:0] node [2*N_MACS-1];

    always_comb begin
        for (int i = 0; i < N_MACS; i++) begin
            node[N_MACS-1+i] = SUM_W'($signed(prod_i[i]));
        end
        for (int k = N_MACS - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
        sum_o = node[0];
    end

endmodule

// File: rtl/mac_array.sv
// Three-stage signed int8 MAC engine (multiply, reduce, accumulate).
// Optional saturating accumulate with sticky overflow under `MAC_SAT_EN.
module mac_array
    import dscnn_pkg::*;
#(
    parameter int N_MACS = DEF_N_MACS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic        clk,
    input  logic        reset_n,
    mac_array_if.slave  mac
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = sum_w(N_MACS, DATA_W);

    logic [N_MACS-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                          v1_q, v1_d;
    logic signed [SUM_W-1:0]       sum_q, sum_d;
    logic                          v2_q, v2_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic                          dirty_q, dirty_d;
    logic signed [SUM_W-1:0]       tree_sum;
    logic signed [ACC_W-1:0]       sum_ext;
    logic signed [ACC_W-1:0]       add_res;

    // Products only load on mac_en, so idle-cycle lane garbage never reaches S2.
    always_comb begin
        prod_d = prod_q;
        if (mac.mac_en) begin
            for (int i = 0; i < N_MACS; i++) begin
                prod_d[i] = PROD_W'($signed(mac.mac_ifmap[i])) * PROD_W'($signed(mac.mac_weight[i]));
            end
        end
    end

    mac_adder_tree #(
        .N_MACS (N_MACS),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_tree (
        .prod_i (prod_q),
        .sum_o  (tree_sum)
    );

    assign sum_ext = ACC_W'(sum_q);

`ifdef MAC_SAT_EN
    logic signed [ACC_W:0] wide_sum;
    logic                  add_ovf;
    logic                  ovf_q, ovf_d;

    always_comb begin
        wide_sum = {acc_q[ACC_W-1], acc_q} + {sum_ext[ACC_W-1], sum_ext};
        add_ovf  = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
        add_res  = wide_sum[ACC_W-1:0];
        if (add_ovf) begin
            add_res = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign add_res = acc_q + sum_ext;
`endif

    // A clear only kills older beats; a beat presented with it still enters S1.
    always_comb begin
        v1_d    = mac.mac_en;
        sum_d   = v1_q ? tree_sum : sum_q;
        v2_d    = v1_q & ~mac.mac_clear;
        acc_d   = acc_q;
        dirty_d = dirty_q;
        if (mac.mac_clear) begin
            acc_d   = mac.mac_bias;
            dirty_d = 1'b0;
        end else if (v2_q) begin
            acc_d   = add_res;
            dirty_d = 1'b1;
        end
    end

`ifdef MAC_SAT_EN
    always_comb begin
        ovf_d = ovf_q;
        if (mac.mac_clear) begin
            ovf_d = 1'b0;
        end else if (v2_q && add_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign mac.mac_ovf = ovf_q;
`else
    assign mac.mac_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q  <= '0;
            v1_q    <= 1'b0;
            sum_q   <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            dirty_q <= dirty_d;
        end
    end

    assign mac.mac_acc   = acc_q;
    assign mac.mac_valid = dirty_q & ~v1_q & ~v2_q;

endmodule
